md_scheduler: RTL and testbench

- Sequences the multi-cycle multiply/divide unit in the E stage of the five-stage MIPS pipeline and owns the HI/LO architectural registers.
- Accepts one mult/multu/div/divu/mthi/mtlo command per cycle from the E stage.
- Counts out the fixed operation latency, then commits the results to HI/LO.
- Drives a stall request that the hazard controller ORs into its PC/IF_ID hold and ID_EX clear when the D-stage instruction touches HI/LO during a busy period.

---
 rtl/md_scheduler.sv | 142 ++++++++++++++
 tb/tb_md_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, counts out the fixed
// operation latency, and raises the D-stage stall while a result is pending.
module md_scheduler #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        D_md,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        md_stall
);

   typedef enum logic {IDLE, RUN} state_t;
   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } op_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      hi_q, lo_q, hi_n, lo_n;
   logic [31:0]      pend_hi, pend_lo, pend_hi_n, pend_lo_n;
   logic             pend_wr, pend_wr_n;
   logic             done_q, done_n;

   op_t         op;
   logic        is_md, is_div, b_zero, div_sgn;
   logic [63:0] smul, umul, res;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, dq, dr;

   assign op     = op_t'(md_op);
   assign is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   assign is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign b_zero = (b == '0);

   assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign umul = {32'b0, a} * {32'b0, b};

   // Signed divide runs on magnitudes; negating 0x80000000 leaves it unchanged,
   // which yields the required 0x80000000 / -1 = 0x80000000 without a special case.
   assign div_sgn = (op == OP_DIV);
   assign a_mag   = (div_sgn && a[31]) ? -a : a;
   assign b_mag   = (div_sgn && b[31]) ? -b : b;
   assign q_mag   = b_zero ? '0 : a_mag / b_mag;
   assign r_mag   = b_zero ? '0 : a_mag % b_mag;
   assign dq      = (div_sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
   assign dr      = (div_sgn && a[31]) ? -r_mag : r_mag;

   always_comb begin
      res = '0;
      case (op)
         OP_MULT:         res = smul;
         OP_MULTU:        res = umul;
         OP_DIV, OP_DIVU: res = {dr, dq};
         default:         res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         hi_q    <= hi_n;
         lo_q    <= lo_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
         pend_wr <= pend_wr_n;
         done_q  <= done_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      hi_n      = hi_q;
      lo_n      = lo_q;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      pend_wr_n = pend_wr;
      done_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (is_md) begin
                  pend_hi_n = res[63:32];
                  pend_lo_n = res[31:0];
                  pend_wr_n = !(is_div && b_zero);
                  cnt_n     = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                  state_n   = RUN;
               end else if (op == OP_MTHI) begin
                  hi_n = a;
               end else if (op == OP_MTLO) begin
                  lo_n = a;
               end
            end
         end
         RUN: begin
            if (cnt == '0) begin
               if (pend_wr) begin
                  hi_n = pend_hi;
                  lo_n = pend_lo;
               end
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
      endcase
   end

   assign busy     = (state == RUN);
   assign done     = done_q;
   assign HI       = hi_q;
   assign LO       = lo_q;
   assign md_stall = D_md && (busy || (start && is_md));

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed scenarios with fixed expected
// values plus a randomized run against a cycle-level behavioural model.
module tb_md_scheduler;

   logic        clk = 1'b0;
   logic        reset, start, D_md;
   logic [2:0]  md_op;
   logic [31:0] a, b;
   logic        busy, done, md_stall;
   logic [31:0] HI, LO;

   int errors = 0;
   int checks = 0;

   md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
      .D_md(D_md), .busy(busy), .done(done), .HI(HI), .LO(LO), .md_stall(md_stall)
   );

   always #5 clk = ~clk;

   // Model: remaining busy cycles plus the architectural result of the op.
   logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
   bit          m_wr = 1'b0, m_done = 1'b0;
   int          m_left = 0;

   function automatic void ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] hi, output logic [31:0] lo, output bit wr);
      longint          sx, sy, q, r;
      longint unsigned ux, uy;
      logic [63:0]     p;
      sx = $signed(x);
      sy = $signed(y);
      ux = x;
      uy = y;
      p  = '0;
      wr = 1'b1;
      case (op)
         3'd1: p = sx * sy;
         3'd2: p = ux * uy;
         3'd3: if (y == 0) wr = 1'b0; else begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
         3'd4: if (y == 0) wr = 1'b0; else begin q = longint'(ux / uy); r = longint'(ux % uy); p = {r[31:0], q[31:0]}; end
         default: wr = 1'b0;
      endcase
      hi = p[63:32];
      lo = p[31:0];
   endfunction

   function automatic bit exp_stall();
      return D_md && ((m_left > 0) || (start && (md_op >= 3'd1) && (md_op <= 3'd4)));
   endfunction

   // Advance one clock edge, updating the model from the inputs seen at that edge.
   task automatic step();
      @(posedge clk);
      if (reset) begin
         m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_wr = 1'b0; m_done = 1'b0; m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               if (m_wr) begin
                  m_hi = m_phi;
                  m_lo = m_plo;
               end
               m_done = 1'b1;
            end
         end else if (start) begin
            case (md_op)
               3'd1, 3'd2, 3'd3, 3'd4: begin
                  ref_op(md_op, a, b, m_phi, m_plo, m_wr);
                  m_left = (md_op <= 3'd2) ? 5 : 10;
               end
               3'd5: m_hi = a;
               3'd6: m_lo = a;
               default: ;
            endcase
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit s, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input bit dm);
      start = s; md_op = op; a = x; b = y; D_md = dm;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 3'd0, '0, '0, 1'b1);
      step();
      step();
      reset = 1'b0;
      checks++;
      if ({busy, done, md_stall, HI, LO} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b stall=%b HI=%h LO=%h, expected all zero", busy, done, md_stall, HI, LO);
      end
   endtask

   task automatic test_arith();
      logic [2:0]  t_op [4] = '{3'd1, 3'd2, 3'd3, 3'd3};
      logic [31:0] t_a  [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000};
      logic [31:0] t_b  [4] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
      logic [31:0] t_hi [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
      logic [31:0] t_lo [4] = '{32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFD, 32'h8000_0000};
      int          t_n  [4] = '{5, 5, 10, 10};
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, t_op[k], t_a[k], t_b[k], 1'b0);
         step();
         drive(1'b0, 3'd0, '0, '0, 1'b0);
         for (int i = 1; i <= t_n[k]; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL arith%0d_busy cycle %0d: busy=%b done=%b, expected busy=1 done=0", k, i, busy, done);
            end
            step();
         end
         checks++;
         if ({busy, done, HI, LO} !== {1'b0, 1'b1, t_hi[k], t_lo[k]}) begin
            errors++;
            $display("FAIL arith%0d_result: busy=%b done=%b HI=%h LO=%h, expected busy=0 done=1 HI=%h LO=%h",
                     k, busy, done, HI, LO, t_hi[k], t_lo[k]);
         end
         step();
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL arith%0d_done_pulse: done=%b, expected 0", k, done);
         end
      end
   endtask

   task automatic test_div_zero();
      drive(1'b1, 3'd5, 32'h1234, '0, 1'b0);
      step();
      drive(1'b1, 3'd6, 32'h5678, '0, 1'b0);
      step();
      drive(1'b0, 3'd0, '0, '0, 1'b0);
      checks++;
      if ({busy, done, HI, LO} !== {1'b0, 1'b0, 32'h1234, 32'h5678}) begin
         errors++;
         $display("FAIL mthi_mtlo: busy=%b done=%b HI=%h LO=%h, expected 0 0 00001234 00005678", busy, done, HI, LO);
      end
      drive(1'b1, 3'd4, 32'd5, 32'd0, 1'b0);
      step();
      drive(1'b0, 3'd0, '0, '0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL divzero_busy cycle %0d: busy=%b done=%b, expected busy=1 done=0", i, busy, done);
         end
         step();
      end
      checks++;
      if ({busy, done, HI, LO} !== {1'b0, 1'b1, 32'h1234, 32'h5678}) begin
         errors++;
         $display("FAIL divzero_result: busy=%b done=%b HI=%h LO=%h, expected 0 1 00001234 00005678", busy, done, HI, LO);
      end
      step();
   endtask

   task automatic test_stall_and_ignore();
      drive(1'b1, 3'd1, 32'd7, 32'd6, 1'b1);
      checks++;
      if (md_stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_issue_cycle: md_stall=%b, expected 1", md_stall);
      end
      step();
      for (int i = 1; i <= 5; i++) begin
         // Commands offered while busy must be ignored; stop offering before the done cycle.
         drive(i < 5, 3'd3, 32'd1000, 32'd3, 1'b1);
         checks++;
         if (md_stall !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_busy cycle %0d: md_stall=%b busy=%b, expected 1 1", i, md_stall, busy);
         end
         step();
      end
      checks++;
      if ({md_stall, done, HI, LO} !== {1'b0, 1'b1, 32'h0, 32'd42}) begin
         errors++;
         $display("FAIL stall_release: md_stall=%b done=%b HI=%h LO=%h, expected 0 1 00000000 0000002a", md_stall, done, HI, LO);
      end
      drive(1'b1, 3'd5, 32'hABCD, '0, 1'b0);
      step();
      drive(1'b0, 3'd0, '0, '0, 1'b0);
      checks++;
      if (HI !== 32'hABCD) begin
         errors++;
         $display("FAIL start_in_done_cycle: HI=%h, expected 0000abcd", HI);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 3'd6, 32'hDEAD, '0, 1'b0);
      step();
      drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
      step();
      drive(1'b0, 3'd0, '0, '0, 1'b0);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({busy, done, HI, LO} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b HI=%h LO=%h, expected all zero", busy, done, HI, LO);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if ({busy, done, HI, LO} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_after cycle %0d: busy=%b done=%b HI=%h LO=%h, expected all zero", i, busy, done, HI, LO);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] ra, rb;
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 17);
            default: rb = $urandom;
         endcase
         drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
         checks++;
         if ({busy, done, md_stall, HI, LO} !== {m_left > 0, m_done, exp_stall(), m_hi, m_lo}) begin
            errors++;
            $display("FAIL random cycle %0d: busy=%b done=%b stall=%b HI=%h LO=%h, expected busy=%b done=%b stall=%b HI=%h LO=%h",
                     i, busy, done, md_stall, HI, LO, m_left > 0, m_done, exp_stall(), m_hi, m_lo);
         end
         step();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      md_op = '0;
      a     = '0;
      b     = '0;
      D_md  = 1'b0;
      @(negedge clk);
      test_reset();
      test_arith();
      test_div_zero();
      test_stall_and_ignore();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
